// File: rtl/instr_decode.sv
// Instruction decode stage: register file with write-through bypass,
// opcode decode into one-hot ALU select plus control, operand fetch and
// data-hazard (forwarding select) detection against the previous issue.
// All outputs are registered, one cycle behind instr/instr_valid.
module instr_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   input  logic        flush,
   input  logic        wb_en,
   input  logic [3:0]  wb_addr,
   input  logic [15:0] wb_data,
   output logic        is_add,
   output logic        is_sub,
   output logic        is_and,
   output logic        is_or,
   output logic        is_gt,
   output logic        is_eq,
   output logic        is_mem_write,
   output logic        is_reg_write,
   output logic        is_halt,
   output logic        is_branch,
   output logic [15:0] val1,
   output logic [15:0] val2,
   output logic [15:0] val3,
   output logic        is_val1_data_hazard,
   output logic        is_val2_data_hazard,
   output logic        is_mem_data_hazard
);

   // Control vector bit positions: {add,sub,and,or,gt,eq,mem_write,reg_write,halt,branch}
   localparam logic [9:0] C_ADD  = 10'b10_0000_0000;
   localparam logic [9:0] C_EQ   = 10'b00_0001_0000;
   localparam logic [9:0] C_MEMW = 10'b00_0000_1000;
   localparam logic [9:0] C_REGW = 10'b00_0000_0100;
   localparam logic [9:0] C_HALT = 10'b00_0000_0010;
   localparam logic [9:0] C_BR   = 10'b00_0000_0001;

   localparam logic [3:0] OP_LOAD  = 4'd6;
   localparam logic [3:0] OP_STORE = 4'd7;
   localparam logic [3:0] OP_BEQ   = 4'd8;
   localparam logic [3:0] OP_LI    = 4'd9;
   localparam logic [3:0] OP_HALT  = 4'd15;

   logic [15:0] r_regs [16];
   logic [9:0]  r_ctrl;
   logic [15:0] r_val1, r_val2, r_val3;
   logic        r_haz1, r_haz2, r_hazm;
   logic [3:0]  r_last_rd;
   logic        r_last_wr, r_last_load;
   logic        r_halted;

   logic [3:0]  w_op, w_rd, w_rs1, w_rs2;
   logic [15:0] w_rs1_val, w_rs2_val, w_rd_val;
   logic        w_rs1_hit, w_rs2_hit;
   logic [9:0]  w_ctrl;
   logic [15:0] w_val1, w_val2, w_val3;
   logic        w_haz1, w_haz2, w_hazm;
   logic        w_track_wr, w_track_load, w_halted_n;

   assign w_op  = instr[15:12];
   assign w_rd  = instr[11:8];
   assign w_rs1 = instr[7:4];
   assign w_rs2 = instr[3:0];

   // r0 is hard zero; a same-cycle writeback to the read index is passed through
   assign w_rs1_val = (w_rs1 == 4'd0) ? 16'd0 :
                      (wb_en && (wb_addr == w_rs1)) ? wb_data : r_regs[w_rs1];
   assign w_rs2_val = (w_rs2 == 4'd0) ? 16'd0 :
                      (wb_en && (wb_addr == w_rs2)) ? wb_data : r_regs[w_rs2];
   assign w_rd_val  = (w_rd == 4'd0) ? 16'd0 :
                      (wb_en && (wb_addr == w_rd)) ? wb_data : r_regs[w_rd];

   // A source matches the register written by the instruction issued last cycle
   assign w_rs1_hit = r_last_wr && (r_last_rd != 4'd0) && (w_rs1 == r_last_rd);
   assign w_rs2_hit = r_last_wr && (r_last_rd != 4'd0) && (w_rs2 == r_last_rd);

   // Decode the current instruction into next-cycle controls, operands and hazard flags
   always_comb begin
      w_ctrl       = 10'd0;
      w_val1       = 16'd0;
      w_val2       = 16'd0;
      w_val3       = 16'd0;
      w_haz1       = 1'b0;
      w_haz2       = 1'b0;
      w_track_wr   = 1'b0;
      w_track_load = 1'b0;
      w_halted_n   = r_halted;
      if (r_halted) begin
         w_ctrl = C_HALT;
      end else if (instr_valid && !flush) begin
         case (w_op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
               w_ctrl     = C_REGW | (C_ADD >> w_op);
               w_val1     = w_rs1_val;
               w_val2     = w_rs2_val;
               w_val3     = {12'd0, w_rd};
               w_haz1     = w_rs1_hit;
               w_haz2     = w_rs2_hit;
               w_track_wr = 1'b1;
            end
            OP_LOAD: begin
               w_ctrl       = C_ADD | C_REGW;
               w_val1       = w_rs1_val;
               w_val3       = {12'd0, w_rd};
               w_haz1       = w_rs1_hit;
               w_track_wr   = 1'b1;
               w_track_load = 1'b1;
            end
            OP_STORE: begin
               w_ctrl = C_ADD | C_MEMW;
               w_val1 = w_rs1_val;
               w_val2 = w_rs2_val;
               w_haz1 = w_rs1_hit;
               w_haz2 = w_rs2_hit;
            end
            OP_BEQ: begin
               // Execute masks reg_write for branches, so it is not tracked as a writer
               w_ctrl = C_EQ | C_REGW | C_BR;
               w_val1 = w_rs1_val;
               w_val2 = w_rs2_val;
               w_val3 = w_rd_val;
               w_haz1 = w_rs1_hit;
            end
            OP_LI: begin
               w_ctrl     = C_ADD | C_REGW;
               w_val1     = {8'd0, instr[7:0]};
               w_val3     = {12'd0, w_rd};
               w_track_wr = 1'b1;
            end
            OP_HALT: begin
               w_ctrl     = C_HALT;
               w_halted_n = 1'b1;
            end
            default: begin
               w_ctrl = 10'd0;
            end
         endcase
      end else begin
         w_ctrl = 10'd0;
      end
      w_hazm = r_last_load && (w_haz1 || w_haz2);
   end

   // Register file: r0 is never written; writeback proceeds even during a flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            r_regs[i] <= 16'd0;
         end
      end else if (wb_en && (wb_addr != 4'd0)) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   // Output, hazard-tracking and halt registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl      <= 10'd0;
         r_val1      <= 16'd0;
         r_val2      <= 16'd0;
         r_val3      <= 16'd0;
         r_haz1      <= 1'b0;
         r_haz2      <= 1'b0;
         r_hazm      <= 1'b0;
         r_last_rd   <= 4'd0;
         r_last_wr   <= 1'b0;
         r_last_load <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_ctrl      <= w_ctrl;
         r_val1      <= w_val1;
         r_val2      <= w_val2;
         r_val3      <= w_val3;
         r_haz1      <= w_haz1;
         r_haz2      <= w_haz2;
         r_hazm      <= w_hazm;
         r_last_rd   <= w_track_wr ? w_rd : 4'd0;
         r_last_wr   <= w_track_wr;
         r_last_load <= w_track_load;
         r_halted    <= w_halted_n;
      end
   end

   assign {is_add, is_sub, is_and, is_or, is_gt, is_eq,
           is_mem_write, is_reg_write, is_halt, is_branch} = r_ctrl;
   assign val1                = r_val1;
   assign val2                = r_val2;
   assign val3                = r_val3;
   assign is_val1_data_hazard = r_haz1;
   assign is_val2_data_hazard = r_haz2;
   assign is_mem_data_hazard  = r_hazm;

endmodule

// File: tb/tb_instr_decode.sv
// Directed testbench for instr_decode with hand-computed expected values.
module tb_instr_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = 16'd0;
   logic        flush = 1'b0;
   logic        wb_en = 1'b0;
   logic [3:0]  wb_addr = 4'd0;
   logic [15:0] wb_data = 16'd0;
   logic        is_add, is_sub, is_and, is_or, is_gt, is_eq;
   logic        is_mem_write, is_reg_write, is_halt, is_branch;
   logic [15:0] val1, val2, val3;
   logic        is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard;

   int n_tests = 0;
   int n_fail  = 0;

   // Control encodings {add,sub,and,or,gt,eq,mem_write,reg_write,halt,branch}
   localparam logic [9:0] K_NONE  = 10'b0000000000;
   localparam logic [9:0] K_ADD   = 10'b1000000100;
   localparam logic [9:0] K_SUB   = 10'b0100000100;
   localparam logic [9:0] K_OR    = 10'b0001000100;
   localparam logic [9:0] K_STORE = 10'b1000001000;
   localparam logic [9:0] K_BEQ   = 10'b0000010101;
   localparam logic [9:0] K_HALT  = 10'b0000000010;

   instr_decode dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .is_add(is_add), .is_sub(is_sub), .is_and(is_and), .is_or(is_or),
      .is_gt(is_gt), .is_eq(is_eq), .is_mem_write(is_mem_write),
      .is_reg_write(is_reg_write), .is_halt(is_halt), .is_branch(is_branch),
      .val1(val1), .val2(val2), .val3(val3),
      .is_val1_data_hazard(is_val1_data_hazard),
      .is_val2_data_hazard(is_val2_data_hazard),
      .is_mem_data_hazard(is_mem_data_hazard)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [9:0] c, input logic [15:0] v1,
                            input logic [15:0] v2, input logic [15:0] v3, input logic [2:0] hz);
      check({tag, ".ctrl"}, {6'd0, is_add, is_sub, is_and, is_or, is_gt, is_eq,
                             is_mem_write, is_reg_write, is_halt, is_branch}, {6'd0, c});
      check({tag, ".val1"}, val1, v1);
      check({tag, ".val2"}, val2, v2);
      check({tag, ".val3"}, val3, v3);
      check({tag, ".haz"}, {13'd0, is_val1_data_hazard, is_val2_data_hazard,
                            is_mem_data_hazard}, {13'd0, hz});
   endtask

   // Present one cycle of inputs, then sample 1 time unit after the edge
   task automatic cyc(input logic v, input logic [15:0] ins, input logic fl,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd);
      instr_valid = v; instr = ins; flush = fl;
      wb_en = we; wb_addr = wa; wb_data = wd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held
      cyc(1'b1, 16'h0312, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("reset", K_NONE, 16'd0, 16'd0, 16'd0, 3'b000);
      rst = 1'b0;
      // No valid instruction after reset -> bubble
      cyc(1'b0, 16'h0312, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("post_reset_bubble", K_NONE, 16'd0, 16'd0, 16'd0, 3'b000);

      // LI r1,5 ; LI r2,7 (writes r1=5) ; ADD r3,r1,r2 (bypass r2=7)
      cyc(1'b1, 16'h9105, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("li_r1", K_ADD, 16'd5, 16'd0, 16'd1, 3'b000);
      cyc(1'b1, 16'h9207, 1'b0, 1'b1, 4'd1, 16'd5);
      check_all("li_r2", K_ADD, 16'd7, 16'd0, 16'd2, 3'b000);
      cyc(1'b1, 16'h0312, 1'b0, 1'b1, 4'd2, 16'd7);
      check_all("add_r3", K_ADD, 16'd5, 16'd7, 16'd3, 3'b010);

      // ADD r4,r1,r2 then SUB r5,r4,r4 -> both source hazards
      cyc(1'b1, 16'h0412, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("add_r4", K_ADD, 16'd5, 16'd7, 16'd4, 3'b000);
      cyc(1'b1, 16'h1544, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("sub_r5", K_SUB, 16'd0, 16'd0, 16'd5, 3'b110);

      // LOAD r6,r1 then ADD r7,r6,r0 -> load-use hazard
      cyc(1'b1, 16'h6610, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("load_r6", K_ADD, 16'd5, 16'd0, 16'd6, 3'b000);
      cyc(1'b1, 16'h0760, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("add_r7", K_ADD, 16'd0, 16'd0, 16'd7, 3'b101);

      // OR r8,r2,r0 with same-cycle write r2=0x1234
      cyc(1'b1, 16'h3820, 1'b0, 1'b1, 4'd2, 16'h1234);
      check_all("or_bypass", K_OR, 16'h1234, 16'd0, 16'd8, 3'b000);

      // Flush with ADD r9 present; writeback r10=0xBEEF must still land
      cyc(1'b1, 16'h0911, 1'b1, 1'b1, 4'd10, 16'hBEEF);
      check_all("flush", K_NONE, 16'd0, 16'd0, 16'd0, 3'b000);
      cyc(1'b1, 16'h1A99, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("sub_after_flush", K_SUB, 16'd0, 16'd0, 16'd10, 3'b000);
      // OR r11,r10,r0: reads write made during flush; SUB r10 was a writer
      cyc(1'b1, 16'h3BA0, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("or_r11", K_OR, 16'hBEEF, 16'd0, 16'd11, 3'b100);

      // STORE rs1=r1 rs2=r2 ; BEQ target r2 ; ADD r1,r2,r2 (BEQ wrote nothing)
      cyc(1'b1, 16'h7012, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("store", K_STORE, 16'd5, 16'h1234, 16'd0, 3'b000);
      cyc(1'b1, 16'h8212, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("beq", K_BEQ, 16'd5, 16'h1234, 16'h1234, 3'b000);
      cyc(1'b1, 16'h0122, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("add_after_beq", K_ADD, 16'h1234, 16'h1234, 16'd1, 3'b000);

      // Unused opcodes decode as bubbles
      cyc(1'b1, 16'hC123, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("op12_bubble", K_NONE, 16'd0, 16'd0, 16'd0, 3'b000);
      cyc(1'b1, 16'hA5FF, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("op10_bubble", K_NONE, 16'd0, 16'd0, 16'd0, 3'b000);

      // Halt is sticky; later ADD is ignored
      cyc(1'b1, 16'hF000, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("halt", K_HALT, 16'd0, 16'd0, 16'd0, 3'b000);
      cyc(1'b1, 16'h0312, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("halted_add", K_HALT, 16'd0, 16'd0, 16'd0, 3'b000);
      cyc(1'b1, 16'h9105, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("halted_li", K_HALT, 16'd0, 16'd0, 16'd0, 3'b000);

      // Asynchronous reset clears outputs immediately and the register file
      rst = 1'b1;
      #1;
      check_all("async_reset", K_NONE, 16'd0, 16'd0, 16'd0, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, 16'h0310, 1'b0, 1'b0, 4'd0, 16'd0);
      check_all("after_reset_r1", K_ADD, 16'd0, 16'd0, 16'd3, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
